// File: rtl/snake_logic.sv
// Snake game board sequencer: moves, collisions, growth, food placement and blink.
// Optional SNAKE_WRAP_EN: board edges wrap instead of ending the game.
module snake_logic #(
  parameter int START_LEN = 3
) (
  input  logic        clka,
  input  logic        restart,
  input  logic        tick,
  input  logic        no_update,
  input  logic [1:0]  direction_state,
  input  logic [5:0]  rand_value,
  input  logic        rand_valid,
  output logic        rand_req,
  output logic [1:0]  from_logic,
  output logic [63:0] led_array
);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [63:0] OCC_RESET = 64'(((64'd1 << START_LEN) - 64'd1) << 25);
  localparam logic [5:0]  FOOD_RESET = 6'd45;

  typedef enum logic [2:0] {
    IDLE, MOVE, CHECK, COMMIT, FOOD, DEAD, BLINK
  } state_t;

  state_t state_reg, state_next;

  logic [5:0]  body_mem [64];
  logic [5:0]  head_ptr_reg, tail_ptr_reg;
  logic [6:0]  length_reg;
  logic [63:0] occ_reg;
  logic [5:0]  food_reg;
  logic        head_blank_reg;
  logic [1:0]  dir_reg;
  logic [5:0]  nh_reg;
  logic        eat_reg;
  logic        done_reg, game_end_reg, rand_req_reg;

  logic [5:0]  head_pos, tail_pos;
  logic [2:0]  head_row, head_col, nh_row, nh_col;
  logic        wall_hit;
  logic        eat_now, hit_now, food_free, accept;
  logic [63:0] occ_commit;

  assign head_pos  = body_mem[head_ptr_reg];
  assign tail_pos  = body_mem[tail_ptr_reg];
  assign head_row  = head_pos[5:3];
  assign head_col  = head_pos[2:0];
  assign eat_now   = (nh_reg == food_reg);
  // The tail cell is vacated on a non-eating move, so stepping into it is legal.
  assign hit_now   = occ_reg[nh_reg] && !((nh_reg == tail_pos) && !eat_now);
  assign food_free = !occ_reg[rand_value];
  assign accept    = (state_reg == IDLE) && tick;

  always_comb begin
    nh_row   = head_row;
    nh_col   = head_col;
    wall_hit = 1'b0;
    case (dir_reg)
      DIR_UP:    nh_row = head_row + 3'd1;
      DIR_DOWN:  nh_row = head_row - 3'd1;
      DIR_LEFT:  nh_col = head_col - 3'd1;
      default:   nh_col = head_col + 3'd1;
    endcase
`ifndef SNAKE_WRAP_EN
    case (dir_reg)
      DIR_UP:    wall_hit = (head_row == 3'd7);
      DIR_DOWN:  wall_hit = (head_row == 3'd0);
      DIR_LEFT:  wall_hit = (head_col == 3'd0);
      DIR_RIGHT: wall_hit = (head_col == 3'd7);
      default:   wall_hit = 1'b0;
    endcase
`endif
  end

  always_comb begin
    occ_commit = occ_reg;
    if (!eat_reg) occ_commit[tail_pos] = 1'b0;
    occ_commit[nh_reg] = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (tick) state_next = (no_update || game_end_reg) ? BLINK : MOVE;
      MOVE:   state_next = wall_hit ? DEAD : CHECK;
      CHECK:  state_next = hit_now ? DEAD : COMMIT;
      COMMIT: begin
        if (eat_reg && (length_reg == 7'd63)) state_next = DEAD;
        else if (eat_reg)                     state_next = FOOD;
        else                                  state_next = IDLE;
      end
      FOOD:   if (rand_valid && food_free) state_next = IDLE;
      DEAD:   state_next = IDLE;
      BLINK:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(negedge clka) begin
    if (restart) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Flags are raised on the edge that enters DEAD so wall and body hits report
  // one edge after the state that detected them.
  always_ff @(negedge clka) begin
    if (restart) begin
      done_reg     <= 1'b0;
      game_end_reg <= 1'b0;
      rand_req_reg <= 1'b0;
    end else begin
      rand_req_reg <= (state_next == FOOD);
      if (accept) begin
        done_reg <= 1'b0;
      end else if (state_next == DEAD) begin
        done_reg     <= 1'b1;
        game_end_reg <= 1'b1;
      end else if ((state_next == IDLE) && (state_reg != IDLE)) begin
        done_reg <= 1'b1;
      end
    end
  end

  always_ff @(negedge clka) begin
    if (restart) begin
      for (int i = 0; i < 64; i++)
        body_mem[i] <= (i < START_LEN) ? {3'd3, 3'(i + 1)} : 6'd0;
      head_ptr_reg   <= 6'(START_LEN - 1);
      tail_ptr_reg   <= 6'd0;
      length_reg     <= 7'(START_LEN);
      occ_reg        <= OCC_RESET;
      food_reg       <= FOOD_RESET;
      head_blank_reg <= 1'b0;
      dir_reg        <= DIR_UP;
      nh_reg         <= 6'd0;
      eat_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE:  if (tick) dir_reg <= direction_state;
        MOVE:  nh_reg <= {nh_row, nh_col};
        CHECK: eat_reg <= eat_now;
        COMMIT: begin
          body_mem[head_ptr_reg + 6'd1] <= nh_reg;
          head_ptr_reg <= head_ptr_reg + 6'd1;
          occ_reg      <= occ_commit;
          if (eat_reg) length_reg   <= length_reg + 7'd1;
          else         tail_ptr_reg <= tail_ptr_reg + 6'd1;
        end
        FOOD:  if (rand_valid && food_free) food_reg <= rand_value;
        BLINK: head_blank_reg <= !head_blank_reg;
        default: ;
      endcase
    end
  end

  always_comb begin
    led_array = occ_reg | (64'd1 << food_reg);
    if (head_blank_reg) led_array[head_pos] = 1'b0;
  end

  assign rand_req   = rand_req_reg;
  assign from_logic = {game_end_reg, done_reg};

endmodule

// File: tb/tb_snake_logic.sv
// Directed bench for snake_logic: move, eat/food, collisions, wall, blink, reset in FOOD.
module tb_snake_logic;

  logic        clka;
  logic        restart;
  logic        tick;
  logic        no_update;
  logic [1:0]  direction_state;
  logic [5:0]  rand_value;
  logic        rand_valid;
  logic        rand_req;
  logic [1:0]  from_logic;
  logic [63:0] led_array;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;
  localparam logic [63:0] IMG_RESET = 64'h0000_2000_0E00_0000;

  snake_logic #(.START_LEN(3)) dut (
    .clka(clka),
    .restart(restart),
    .tick(tick),
    .no_update(no_update),
    .direction_state(direction_state),
    .rand_value(rand_value),
    .rand_valid(rand_valid),
    .rand_req(rand_req),
    .from_logic(from_logic),
    .led_array(led_array)
  );

  initial clka = 1'b1;
  always #5 clka = ~clka;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic do_reset();
    @(posedge clka);
    restart = 1'b1;
    @(posedge clka);
    restart = 1'b0;
  endtask

  // One idle cycle first so a one-cycle DEAD state has returned to IDLE.
  task automatic run_tick(input logic [1:0] dir, input logic nu, input int exp_lat, input string tag);
    int lat;
    @(posedge clka);
    tick = 1'b1;
    direction_state = dir;
    no_update = nu;
    @(posedge clka);
    tick = 1'b0;
    no_update = 1'b0;
    lat = 0;
    while (!from_logic[0] && lat < 20) begin
      @(posedge clka);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic approach_food();
    do_reset();
    run_tick(RIGHT, 1'b0, 3, "ap r1");
    run_tick(RIGHT, 1'b0, 3, "ap r2");
    run_tick(UP,    1'b0, 3, "ap u1");
  endtask

  // Final UP onto (5,5); returns at the sample point after E3.
  task automatic eat_tick(input string tag);
    @(posedge clka);
    tick = 1'b1;
    direction_state = UP;
    @(posedge clka);
    tick = 1'b0;
    @(posedge clka);
    @(posedge clka);
    check({tag, " rand_req E2"}, 64'(rand_req), 64'd0);
    @(posedge clka);
    check({tag, " rand_req E3"}, 64'(rand_req), 64'd1);
    check({tag, " done E3"}, 64'(from_logic[0]), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    restart = 1'b1;
    tick = 1'b0;
    no_update = 1'b0;
    direction_state = UP;
    rand_value = 6'd0;
    rand_valid = 1'b0;
    repeat (2) @(posedge clka);
    restart = 1'b0;

    check("reset led", led_array, IMG_RESET);
    check("reset from_logic", 64'(from_logic), 64'd0);
    check("reset rand_req", 64'(rand_req), 64'd0);

    // Basic move, stepped edge by edge
    @(posedge clka);
    tick = 1'b1;
    direction_state = RIGHT;
    @(posedge clka);
    tick = 1'b0;
    @(posedge clka);
    check("move done E1", 64'(from_logic[0]), 64'd0);
    @(posedge clka);
    check("move done E2", 64'(from_logic[0]), 64'd0);
    check("move led E2", led_array, IMG_RESET);
    @(posedge clka);
    check("move from_logic E3", 64'(from_logic), 64'd1);
    check("move led E3", led_array, 64'h0000_2000_1C00_0000);

    // Eat and food placement
    approach_food();
    eat_tick("eat");
    check("eat led", led_array, 64'h0000_2020_3000_0000);
    tick = 1'b1;
    direction_state = RIGHT;
    @(posedge clka);
    tick = 1'b0;
    check("food tick ignored rand_req", 64'(rand_req), 64'd1);
    check("food tick ignored done", 64'(from_logic[0]), 64'd0);
    rand_valid = 1'b1;
    rand_value = 6'd45;
    @(posedge clka);
    rand_valid = 1'b0;
    check("food reject rand_req", 64'(rand_req), 64'd1);
    check("food reject done", 64'(from_logic[0]), 64'd0);
    check("food reject led", led_array, 64'h0000_2020_3000_0000);
    rand_valid = 1'b1;
    rand_value = 6'd0;
    @(posedge clka);
    rand_valid = 1'b0;
    check("food accept rand_req", 64'(rand_req), 64'd0);
    check("food accept from_logic", 64'(from_logic), 64'd1);
    check("food accept led", led_array, 64'h0000_2020_3000_0001);
    run_tick(RIGHT, 1'b0, 3, "grown move");
    check("grown move led", led_array, 64'h0000_6020_2000_0001);

    // Body collision, then blink
    do_reset();
    run_tick(LEFT, 1'b0, 2, "body hit");
    check("body hit from_logic", 64'(from_logic), 64'd3);
    check("body hit led", led_array, IMG_RESET);
    run_tick(UP, 1'b1, 1, "blink1");
    check("blink1 led", led_array, 64'h0000_2000_0600_0000);
    check("blink1 from_logic", 64'(from_logic), 64'd3);
    run_tick(UP, 1'b1, 1, "blink2");
    check("blink2 led", led_array, IMG_RESET);
    run_tick(RIGHT, 1'b0, 1, "blink3");
    check("blink3 led", led_array, 64'h0000_2000_0600_0000);

    // Wall
    do_reset();
    for (int i = 0; i < 4; i++) run_tick(RIGHT, 1'b0, 3, "wall approach");
    check("wall approach led", led_array, 64'h0000_2000_E000_0000);
`ifdef SNAKE_WRAP_EN
    run_tick(RIGHT, 1'b0, 3, "wrap");
    check("wrap from_logic", 64'(from_logic), 64'd1);
    check("wrap led", led_array, 64'h0000_2000_C100_0000);
`else
    run_tick(RIGHT, 1'b0, 1, "wall");
    check("wall from_logic", 64'(from_logic), 64'd3);
    check("wall led", led_array, 64'h0000_2000_E000_0000);
`endif

    // Reset while waiting for food
    approach_food();
    eat_tick("midfood");
    restart = 1'b1;
    rand_valid = 1'b1;
    rand_value = 6'd0;
    @(posedge clka);
    restart = 1'b0;
    rand_valid = 1'b0;
    check("midfood rand_req", 64'(rand_req), 64'd0);
    check("midfood from_logic", 64'(from_logic), 64'd0);
    check("midfood led", led_array, IMG_RESET);
    run_tick(RIGHT, 1'b0, 3, "post reset move");
    check("post reset move led", led_array, 64'h0000_2000_1C00_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snake_logic.md
# snake_logic

Game-board datapath sequencer for the snake game. It sits between the top-level game controller and the PRNG. On each tick it moves the snake one cell, detects wall and body collisions, grows the snake and places new food when food is eaten, and handles head blinking after game over. It owns the 8x8 board image that the controller multiplexes onto the LED matrix, and it reports completion and game-over back to the controller.

## Interface
- `START_LEN`, 3: snake length after reset; fixed layout below; legal range 2..4.
- `clka`  in  1  sole clock; all registers update on the falling edge.
- `restart`  in  1  synchronous, active-high reset.
- `tick`  in  1  the controller's to_logic[LOGIC_TICK]; a level request.
- `no_update`  in  1  the controller's to_logic[NO_UPDATE]; blink instead of move.
- `direction_state`  in  2  UP=0, DOWN=1, LEFT=2, RIGHT=3; sampled when a tick is accepted.
- `rand_value`  in  6  PRNG board position, encoded {row[2:0], col[2:0]}.
- `rand_valid`  in  1  rand_value is valid this cycle.
- `rand_req`  out  1  food-position request to the PRNG.
- `from_logic`  out  2  bit 0 is LOGIC_DONE, bit 1 is GAME_END.
- `led_array`  out  64  board image; bit 8*row+col; row 0 is the bottom row, col 0 is the left column.

## Operation
- **Storage**
  - 64x6 circular body buffer with 6-bit `head_ptr` and `tail_ptr`; pointers wrap mod 64.
  - 7-bit `length`.
  - 64-bit occupancy map `occ`.
  - 6-bit `food` register.
  - `head_blank` flag.
- **Board image:** `led_array = (occ | onehot(food))`, with the head bit forced to 0 while `head_blank=1`.
- **Movement:** UP is row+1, DOWN is row-1, LEFT is col-1, RIGHT is col+1.
- **State machine** (all state after IDLE runs on the direction latched at tick acceptance):
  - **IDLE**
    - A tick is accepted only in IDLE.
    - On acceptance: clear LOGIC_DONE and latch `direction_state`.
    - If `no_update=1` or GAME_END is set, go to BLINK; otherwise go to MOVE.
  - **MOVE**
    - Compute `nh` from the head and the latched direction.
    - An out-of-bounds move goes to DEAD (see Configuration); otherwise go to CHECK.
  - **CHECK**
    - `eat = (nh == food)`.
    - `hit = occ[nh] && !(nh == tail && !eat)`. Moving into the vacating tail cell is legal.
    - If `hit`, go to DEAD; otherwise go to COMMIT.
  - **COMMIT**
    - Write `nh` at `head_ptr+1`, advance `head_ptr`, set `occ[nh]`.
    - If `!eat`: clear `occ[tail]` and advance `tail_ptr`.
    - If `eat`: increment `length`.
    - Exit:
      - Board full (`length == 64` after the increment): go to DEAD.
      - `eat`: go to FOOD.
      - Otherwise: go to IDLE and set LOGIC_DONE.
  - **FOOD**
    - Hold `rand_req=1`.
    - On `rand_valid` with `occ[rand_value]=1`: reject the value and keep `rand_req` high.
    - On `rand_valid` with a free cell: `food <= rand_value`, drop `rand_req`, go to IDLE, set LOGIC_DONE.
  - **DEAD:** set GAME_END and LOGIC_DONE, then go to IDLE.
  - **BLINK:** toggle `head_blank`, set LOGIC_DONE, go to IDLE.
- **Output flags**
  - LOGIC_DONE is a level: it stays high from completion until the next accepted tick.
  - GAME_END is sticky until `restart`.
- **Tick handling:** a tick that is still high in the cycle after LOGIC_DONE rises is accepted again as a new tick. The controller drops `tick` before waiting on LOGIC_DONE.

## Timing
- **Reset values**
  - Outputs: state IDLE, `from_logic=0`, `rand_req=0`, `head_blank=0`.
  - Snake: cells (3,1), (3,2), (3,3); `tail_ptr=0`, `head_ptr=2`, `length=3`.
  - Food: (5,5).
  - Resulting `led_array`: bits 25, 26, 27, 45 set, all others 0.
- **Latency:** let E0 be the edge that accepts the tick.
  - Non-eating move: LOGIC_DONE high after E3.
  - Blink: LOGIC_DONE high after E1.
  - Collision: GAME_END and LOGIC_DONE high after E2 (CHECK hit) or after E1 (wall).
  - Eating move: `rand_req` high after E3. LOGIC_DONE rises on the edge after the first `rand_valid` that carries a free cell.
- **`led_array` updates:**
  - Moves and eats: changes only at the COMMIT edge.
  - Food relocation: changes at the FOOD accept edge.
  - Blink: changes at the BLINK edge.
- **`restart` priority**
  - Overrides every state, including FOOD.
  - `rand_req` falls on the reset edge.
  - A `rand_valid` arriving in the same cycle as `restart` is ignored.
- **Ticks outside IDLE:** ignored, with no queuing.

## Configuration
- `SNAKE_WRAP_EN` defined: edges wrap modulo 8 on both row and col. For example, RIGHT from (3,7) moves to (3,0). Walls never end the game.
- `SNAKE_WRAP_EN` undefined: a move off any edge goes to DEAD, and the board is left unchanged.

## Test plan
- **Basic move:** after reset, tick with RIGHT.
  - Required: `led_array` bits 26, 27, 28, 45 set.
  - Required: LOGIC_DONE high after E3; GAME_END=0.
- **Eat and food placement:** ticks RIGHT, RIGHT, UP, UP, so the head reaches (5,5) and eats.
  - Required: `length=4`; `rand_req` high after E3.
  - Drive `rand_valid` with `rand_value=45` (occupied): the value is rejected and `rand_req` stays high.
  - Drive `rand_value=0`: `food=0`, bit 0 set, `rand_req` low, LOGIC_DONE set.
- **Body collision:** from the reset layout, tick with LEFT; `nh=(3,2)` is occupied.
  - Required: GAME_END=1 and LOGIC_DONE=1 after E2.
  - Required: `led_array` unchanged.
- **Wall:** from the reset layout, four RIGHT ticks bring the head to (3,7); a fifth RIGHT tick follows.
  - Without `SNAKE_WRAP_EN`: GAME_END=1.
  - With `SNAKE_WRAP_EN`: bit 24 set and bit 60 unaffected.
- **Blink after game over:** after GAME_END, tick with `no_update=1`.
  - Required: head bit clears and LOGIC_DONE rises after E1.
  - A second tick sets the head bit again.
  - A tick with `no_update=0` still blinks.
- **Reset mid-food:** assert `restart` while in FOOD with `rand_valid=1`.
  - Required: `rand_req=0` and `from_logic=0` after the reset edge.
  - Required: `led_array` holds the reset image (bits 25, 26, 27, 45).
